// File: rtl/writeback.sv
// WB stage: registers the MEM/WB payload, selects ALU or load data and drives the register write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
`ifdef WB_RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_con_wb_regwrite,
    input  logic              i_con_wb_memtoreg,
    input  logic [ADDR_W-1:0] i_addr_WrReg,
    input  logic [DATA_W-1:0] i_data_AluRes,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_data_MemRd,
    output logic              o_stall,
    output logic              o_con_RegWr,
    output logic [ADDR_W-1:0] o_addr_WrReg,
    output logic [DATA_W-1:0] o_data_WrData
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_cnt_retired
`endif
);

    typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

    state_e            state_q, state_d;
    logic              regwr_q, regwr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    // Destination of a load waiting on memory; kept apart so the visible
    // address only changes when the write actually retires.
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwe_q, pwe_d;
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        regwr_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        paddr_d = paddr_q;
        pwe_d   = pwe_q;
`ifdef WB_RETIRE_CNT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    if (i_con_wb_memtoreg && !i_mem_rvalid) begin
                        state_d = StWaitMem;
                        paddr_d = i_addr_WrReg;
                        pwe_d   = i_con_wb_regwrite && (i_addr_WrReg != '0);
                    end else begin
                        regwr_d = i_con_wb_regwrite && (i_addr_WrReg != '0);
                        addr_d  = i_addr_WrReg;
                        data_d  = i_con_wb_memtoreg ? i_data_MemRd : i_data_AluRes;
`ifdef WB_RETIRE_CNT_EN
                        cnt_d   = cnt_q + 1'b1;
`endif
                    end
                end
            end
            StWaitMem: begin
                if (i_mem_rvalid) begin
                    state_d = StIdle;
                    regwr_d = pwe_q;
                    addr_d  = paddr_q;
                    data_d  = i_data_MemRd;
`ifdef WB_RETIRE_CNT_EN
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            regwr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            paddr_q <= '0;
            pwe_q   <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            regwr_q <= regwr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            paddr_q <= paddr_d;
            pwe_q   <= pwe_d;
`ifdef WB_RETIRE_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_stall       = (state_q == StWaitMem);
    assign o_con_RegWr   = regwr_q;
    assign o_addr_WrReg  = addr_q;
    assign o_data_WrData = data_q;
`ifdef WB_RETIRE_CNT_EN
    assign o_cnt_retired = cnt_q;
`endif

endmodule
